core_mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_order_fifo.sv | 72 +++++++
 rtl/core_mem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the core memory arbiter.
//   master_id_e : identifies which master issued a transaction; it is also
//                 the entry type of the response-order FIFO.
//   ORDER_AW    : pointer width of the order FIFO at the default depth.
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    MST_IRAM = 1'b0,
    MST_DRAM = 1'b1
  } master_id_e;

  localparam int MAX_OUTSTANDING_DFLT = 4;
  localparam int ORDER_AW             = $clog2(MAX_OUTSTANDING_DFLT);

endpackage : mem_arb_pkg

// File: rtl/arb_order_fifo.sv
// ---------------------------------------------------------------------------
// arb_order_fifo
// Synchronous FIFO, 2**AW entries of master_id_e, async active-low reset.
// Records the issuing master of every accepted request so the in-order
// responses can be routed back.
// Ports:
//   clk, rst_b        clock, asynchronous active-low reset
//   push, push_id     write request and entry (ignored when full)
//   pop               read request (ignored when empty)
//   head              entry at the read pointer (combinational, valid when !empty)
//   full, empty       occupancy flags
//   count             number of stored entries (0 .. 2**AW)
// ---------------------------------------------------------------------------
module arb_order_fifo
  import mem_arb_pkg::*;
#(
  parameter int AW = ORDER_AW
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       push,
  input  master_id_e push_id,
  input  logic       pop,
  output master_id_e head,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  localparam int DEPTH = 1 << AW;

  master_id_e      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Head is read combinationally so the response path adds no latency;
  // the array is tiny and maps to distributed storage.
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : arb_order_fifo

// File: rtl/core_mem_arbiter.sv
// ---------------------------------------------------------------------------
// core_mem_arbiter
// Merges the core's instruction (iram_*) and data (dram_*) memory ports onto
// one shared memory port (mem_*). All ports use a req/addr_ok/data_ok split
// transaction protocol with in-order responses. An order FIFO remembers the
// issuing master of each accepted request so each data_ok is routed back.
// Request and response paths are purely combinational (zero added latency).
// Ports:
//   clk, rst_b                    clock, asynchronous active-low reset
//   iram_req/write/wstrb/addr/wdata  instruction master request + payload
//   iram_addr_ok/data_ok/rdata       instruction master accept / response
//   dram_*                            same set for the data master
//   mem_req/write/wstrb/addr/wdata   shared port request + payload
//   mem_addr_ok/data_ok/rdata        shared port accept / response
// Build option:
//   MEM_ARB_RR_EN defined   -> round-robin between masters (last-grant reg)
//   MEM_ARB_RR_EN undefined -> fixed priority, dram over iram
// ---------------------------------------------------------------------------
module core_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  // instruction master
  input  logic              iram_req,
  input  logic              iram_write,
  input  logic [XLEN/8-1:0] iram_wstrb,
  input  logic [XLEN-1:0]   iram_addr,
  input  logic [XLEN-1:0]   iram_wdata,
  output logic              iram_addr_ok,
  output logic              iram_data_ok,
  output logic [XLEN-1:0]   iram_rdata,
  // data master
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_addr_ok,
  output logic              dram_data_ok,
  output logic [XLEN-1:0]   dram_rdata,
  // shared memory port
  output logic              mem_req,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int AW = $clog2(MAX_OUTSTANDING);

  logic       r_lock;
  master_id_e r_lock_id;
`ifdef MEM_ARB_RR_EN
  master_id_e r_last;
`endif

  master_id_e w_gnt_id;
  logic       w_gnt_vld;
  logic       w_accept;
  logic       w_pop;
  logic       w_stray_rsp;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  master_id_e w_fifo_head;
  logic [AW:0] w_fifo_count;

  // ------------------------------------------------------------------ grant
  always_comb begin
    w_gnt_id  = MST_DRAM;
    w_gnt_vld = 1'b0;
    if (r_lock) begin
      // An unaccepted request keeps the port until it is taken.
      w_gnt_id  = r_lock_id;
      w_gnt_vld = (r_lock_id == MST_DRAM) ? dram_req : iram_req;
    end else if (iram_req && dram_req) begin
      w_gnt_vld = 1'b1;
`ifdef MEM_ARB_RR_EN
      w_gnt_id  = (r_last == MST_IRAM) ? MST_DRAM : MST_IRAM;
`else
      w_gnt_id  = MST_DRAM;
`endif
    end else if (dram_req) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = MST_DRAM;
    end else if (iram_req) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = MST_IRAM;
    end
  end

  // ---------------------------------------------------------- request path
  // A full order FIFO blocks the request outright; a same-cycle pop does
  // not help, keeping data_ok out of the req/addr_ok combinational cone.
  assign mem_req      = w_gnt_vld & ~w_fifo_full;
  assign w_accept     = mem_req & mem_addr_ok;
  assign iram_addr_ok = w_accept & (w_gnt_id == MST_IRAM);
  assign dram_addr_ok = w_accept & (w_gnt_id == MST_DRAM);

  always_comb begin
    mem_write = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_vld) begin
      if (w_gnt_id == MST_DRAM) begin
        mem_write = dram_write;
        mem_wstrb = dram_wstrb;
        mem_addr  = dram_addr;
        mem_wdata = dram_wdata;
      end else begin
        mem_write = iram_write;
        mem_wstrb = iram_wstrb;
        mem_addr  = iram_addr;
        mem_wdata = iram_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_lock    <= 1'b0;
      r_lock_id <= MST_IRAM;
    end else begin
      // Locked exactly while a presented request waits for addr_ok.
      r_lock <= mem_req & ~mem_addr_ok;
      if (mem_req && !mem_addr_ok) begin
        r_lock_id <= w_gnt_id;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last <= MST_IRAM;
    end else if (w_accept) begin
      r_last <= w_gnt_id;
    end
  end
`endif

  // ------------------------------------------------------------ order FIFO
  arb_order_fifo #(
    .AW (AW)
  ) u_order_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (w_accept),
    .push_id (w_gnt_id),
    .pop     (w_pop),
    .head    (w_fifo_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // --------------------------------------------------------- response path
  // A data_ok with nothing outstanding is a memory-side protocol error:
  // it is dropped without popping or forwarding.
  assign w_pop        = mem_data_ok & ~w_fifo_empty;
  assign w_stray_rsp  = mem_data_ok & w_fifo_empty;
  assign iram_data_ok = w_pop & (w_fifo_head == MST_IRAM);
  assign dram_data_ok = w_pop & (w_fifo_head == MST_DRAM);
  assign iram_rdata   = mem_rdata;
  assign dram_rdata   = mem_rdata;

  a_no_stray_rsp : assert property (@(posedge clk) disable iff (!rst_b) !w_stray_rsp)
    else $warning("core_mem_arbiter: mem_data_ok with no outstanding transaction");

  a_count_range : assert property (@(posedge clk) disable iff (!rst_b)
                                   w_fifo_count <= (AW+1)'(MAX_OUTSTANDING))
    else $warning("core_mem_arbiter: order FIFO count out of range");

endmodule : core_mem_arbiter
